// File: rtl/gate_seq_pkg.sv
// gate_seq shared types and constants.
// Holds FSM encoding, combo count and standard gate truth tables.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_COMBOS = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  function automatic int cnt_w(input int h);
    return (h <= 1) ? 1 : $clog2(h);
  endfunction

endpackage

// File: rtl/gate_seq_if.sv
// gate_seq bus: start request, gate drive/sense, result outputs.
// master = sequencer side, slave = board/gate side.
interface gate_seq_if
  import gate_seq_pkg::*;
();

  logic                  start;
  logic                  x0;
  logic                  x1;
  logic                  z0;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [NUM_COMBOS-1:0] tt;
  logic [NUM_COMBOS-1:0] fail_mask;

  modport master (
    input  start,
    input  z0,
    output x0,
    output x1,
    output busy,
    output done,
    output pass,
    output tt,
    output fail_mask
  );

  modport slave (
    output start,
    output z0,
    input  x0,
    input  x1,
    input  busy,
    input  done,
    input  pass,
    input  tt,
    input  fail_mask
  );

endinterface

// File: rtl/gate_seq_hold_timer.sv
// hold_timer: counts HOLD_CYCLES per combination.
// tick marks the last cycle of a hold window.
module hold_timer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_w(HOLD_CYCLES);
  localparam logic [W-1:0] LAST = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_seq.sv
// gate_seq: drives 4 input combos into a 2-input gate, checks z0.
// Define GATE_SEQ_AUTORUN_EN to run continuously without start.
module gate_seq
  import gate_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter logic [3:0] EXPECTED    = TT_XOR
) (
  input  logic      clk,
  input  logic      rst_n,
  gate_seq_if.master bus
);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] tt_q, tt_d;
  logic [3:0] fm_q, fm_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] tt_next;
  logic       clr;
  logic       en;
  logic       tick;
  logic       start_eff;

`ifdef GATE_SEQ_AUTORUN_EN
  assign start_eff = 1'b1;
`else
  assign start_eff = bus.start;
`endif

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tt_d    = tt_q;
    fm_d    = fm_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    en      = 1'b0;
    tt_next = tt_q;
    tt_next[idx_q] = bus.z0;
    case (state_q)
      ST_IDLE: begin
        if (start_eff) begin
          state_d = ST_RUN;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          tt_d    = 4'b0000;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        en = 1'b1;
        if (tick) begin
          tt_d = tt_next;
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (tt_next == EXPECTED);
            fm_d    = tt_next ^ EXPECTED;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      tt_q    <= 4'b0000;
      fm_q    <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tt_q    <= tt_d;
      fm_q    <= fm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // gate inputs come straight from registers to stay glitch-free
  assign bus.x0        = busy_q & idx_q[1];
  assign bus.x1        = busy_q & idx_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.tt        = tt_q;
  assign bus.fail_mask = fm_q;

endmodule
